// File: rtl/sram_axi_bridge.sv
// Two SRAM-like CPU ports (inst read-only, data read/write) merged onto one AXI3 master.
// Optional macro AXI_BRIDGE_RBUF_EN registers the R channel before response decode.
module sram_axi_bridge #(
    parameter logic [3:0] DATA_RID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid
);

    typedef enum logic [0:0] {R_IDLE, R_AR} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

    rstate_t     r_rstate, w_rstate_nxt;
    wstate_t     r_wstate, w_wstate_nxt;

    logic        r_inst_busy;
    logic        r_data_busy;

    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [2:0]  r_arsize;

    logic [31:0] r_awaddr;
    logic [2:0]  r_awsize;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid;
    logic        r_wvalid;

    logic        w_rvalid;
    logic [3:0]  w_rid;
    logic [31:0] w_rdata;

    logic        w_inst_rdone;
    logic        w_data_rdone;
    logic        w_wdone;
    logic        w_inst_free;
    logic        w_data_free;
    logic        w_raw_hazard;
    logic        w_inst_acc;
    logic        w_data_rd_acc;
    logic        w_data_wr_acc;
    logic        w_aw_done;
    logic        w_w_done;

    // ------------------------------------------------------------------
    // R channel as seen by the response decoder
    // ------------------------------------------------------------------
`ifdef AXI_BRIDGE_RBUF_EN
    logic        r_rvalid_q;
    logic [3:0]  r_rid_q;
    logic [31:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid_q <= 1'b0;
            r_rid_q    <= 4'd0;
            r_rdata_q  <= 32'd0;
        end else begin
            r_rvalid_q <= rvalid;
            r_rid_q    <= rid;
            r_rdata_q  <= rdata;
        end
    end

    assign w_rvalid = r_rvalid_q;
    assign w_rid    = r_rid_q;
    assign w_rdata  = r_rdata_q;
`else
    assign w_rvalid = rvalid;
    assign w_rid    = rid;
    assign w_rdata  = rdata;
`endif

    // ------------------------------------------------------------------
    // Response decode; beats without a matching outstanding flag are dropped
    // ------------------------------------------------------------------
    assign w_inst_rdone = w_rvalid && (w_rid == 4'd0) && r_inst_busy;
    assign w_data_rdone = w_rvalid && (w_rid == DATA_RID) && r_data_busy;
    assign w_wdone      = bvalid && (r_wstate == W_RESP);

    assign inst_sram_data_ok = w_inst_rdone;
    assign data_sram_data_ok = w_data_rdone || w_wdone;
    assign inst_sram_rdata   = w_rdata;
    assign data_sram_rdata   = w_rdata;

    // A side whose response lands this cycle may take its next request now
    assign w_inst_free = !r_inst_busy || w_inst_rdone;
    assign w_data_free = !r_data_busy || w_data_rdone || w_wdone;

    // Fetch must not overtake a write to the same word still in flight
    assign w_raw_hazard = (r_wstate != W_IDLE) &&
                          (inst_sram_addr[31:2] == r_awaddr[31:2]);

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    assign w_data_rd_acc = data_sram_req && !data_sram_wr && w_data_free &&
                           (r_rstate == R_IDLE);
    assign w_data_wr_acc = data_sram_req && data_sram_wr && w_data_free &&
                           (r_wstate == W_IDLE);
    assign w_inst_acc    = inst_sram_req && w_inst_free && (r_rstate == R_IDLE) &&
                           !w_raw_hazard && !w_data_rd_acc;

    assign inst_sram_addr_ok = w_inst_acc;
    assign data_sram_addr_ok = w_data_rd_acc || w_data_wr_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_busy <= 1'b0;
            r_data_busy <= 1'b0;
        end else begin
            if (w_inst_acc)
                r_inst_busy <= 1'b1;
            else if (w_inst_rdone)
                r_inst_busy <= 1'b0;

            if (w_data_rd_acc || w_data_wr_acc)
                r_data_busy <= 1'b1;
            else if (w_data_rdone || w_wdone)
                r_data_busy <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read address FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: if (w_inst_acc || w_data_rd_acc) w_rstate_nxt = R_AR;
            R_AR:   if (arready)                     w_rstate_nxt = R_IDLE;
            default:                                 w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arid   <= 4'd0;
            r_araddr <= 32'd0;
            r_arsize <= 3'd0;
        end else if (w_data_rd_acc) begin
            r_arid   <= DATA_RID;
            r_araddr <= data_sram_addr;
            r_arsize <= {1'b0, data_sram_size};
        end else if (w_inst_acc) begin
            r_arid   <= 4'd0;
            r_araddr <= inst_sram_addr;
            r_arsize <= 3'd2;
        end
    end

    assign arvalid = (r_rstate == R_AR);
    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arsize  = r_arsize;

    // ------------------------------------------------------------------
    // Write FSM; AW and W retire independently
    // ------------------------------------------------------------------
    assign w_aw_done = !r_awvalid || awready;
    assign w_w_done  = !r_wvalid  || wready;

    always_ff @(posedge clk) begin
        if (reset)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_data_wr_acc)          w_wstate_nxt = W_SEND;
            W_SEND: if (w_aw_done && w_w_done)  w_wstate_nxt = W_RESP;
            W_RESP: if (bvalid)                 w_wstate_nxt = W_IDLE;
            default:                            w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_awaddr  <= 32'd0;
            r_awsize  <= 3'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else if (w_data_wr_acc) begin
            r_awaddr  <= data_sram_addr;
            r_awsize  <= {1'b0, data_sram_size};
            r_wdata   <= data_sram_wdata;
            r_wstrb   <= data_sram_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else begin
            if (r_awvalid && awready) r_awvalid <= 1'b0;
            if (r_wvalid && wready)   r_wvalid  <= 1'b0;
        end
    end

    assign awaddr  = r_awaddr;
    assign awsize  = r_awsize;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wvalid  = r_wvalid;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge; hand-computed expectations.
module tb_sram_axi_bridge;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;

    int n_chk;
    int n_fail;

    sram_axi_bridge #(.DATA_RID(4'd1)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arsize            (arsize),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rvalid            (rvalid),
        .awaddr            (awaddr),
        .awsize            (awsize),
        .awvalid           (awvalid),
        .awready           (awready),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .wvalid            (wvalid),
        .wready            (wready),
        .bvalid            (bvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one R beat; returns once it is visible to the response decoder
    task automatic rbeat(input logic [3:0] id, input logic [31:0] d);
        rid    = id;
        rdata  = d;
        rvalid = 1'b1;
`ifdef AXI_BRIDGE_RBUF_EN
        tick();
        rvalid = 1'b0;
`endif
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1;
        inst_sram_req = 1'b0; inst_sram_addr = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (2) tick();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_dok",     32'(data_sram_data_ok), 32'd0);
        reset = 1'b0;
        tick();

        // simple instruction fetch
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000000; arready = 1'b1; #1;
        chk("t1_iaok", 32'(inst_sram_addr_ok), 32'd1);
        chk("t1_daok", 32'(data_sram_addr_ok), 32'd0);
        tick(); inst_sram_req = 1'b0; #1;
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_arid",    32'(arid),    32'd0);
        chk("t1_arsize",  32'(arsize),  32'd2);
        chk("t1_araddr",  araddr,       32'h1C000000);
        tick(); #1;
        chk("t1_ar_done", 32'(arvalid), 32'd0);
        tick();
        rbeat(4'd0, 32'h02800C0C);
        chk("t1_idok",   32'(inst_sram_data_ok), 32'd1);
        chk("t1_irdata", inst_sram_rdata,        32'h02800C0C);
        chk("t1_ddok",   32'(data_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0; arready = 1'b0;

        // simultaneous inst and data reads: data first
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000010;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd0;
        data_sram_addr = 32'h1C001000; #1;
        chk("t2_daok", 32'(data_sram_addr_ok), 32'd1);
        chk("t2_iaok", 32'(inst_sram_addr_ok), 32'd0);
        tick(); data_sram_req = 1'b0; #1;
        chk("t2_arvalid", 32'(arvalid), 32'd1);
        chk("t2_arid",    32'(arid),    32'd1);
        chk("t2_arsize",  32'(arsize),  32'd0);
        chk("t2_araddr",  araddr,       32'h1C001000);
        chk("t2_iaok_ar", 32'(inst_sram_addr_ok), 32'd0);
        arready = 1'b1; tick(); arready = 1'b0; #1;
        chk("t2_iaok_idle", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; #1;
        chk("t2_arid_i",   32'(arid), 32'd0);
        chk("t2_araddr_i", araddr,    32'h1C000010);
        arready = 1'b1; tick(); arready = 1'b0;
        rbeat(4'd1, 32'hAABBCCDD);
        chk("t2_ddok",   32'(data_sram_data_ok), 32'd1);
        chk("t2_drdata", data_sram_rdata,        32'hAABBCCDD);
        chk("t2_idok0",  32'(inst_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0;
        rbeat(4'd0, 32'h11223344);
        chk("t2_idok",  32'(inst_sram_data_ok), 32'd1);
        chk("t2_ddok0", 32'(data_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0;

        // write with AW lagging W by two cycles
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd1;
        data_sram_wstrb = 4'b0011; data_sram_addr = 32'h1C002004;
        data_sram_wdata = 32'h00001234; #1;
        chk("t3_daok", 32'(data_sram_addr_ok), 32'd1);
        tick(); data_sram_req = 1'b0; data_sram_wr = 1'b0; #1;
        chk("t3_awvalid", 32'(awvalid), 32'd1);
        chk("t3_wvalid",  32'(wvalid),  32'd1);
        chk("t3_awaddr",  awaddr,       32'h1C002004);
        chk("t3_awsize",  32'(awsize),  32'd1);
        chk("t3_wdata",   wdata,        32'h00001234);
        chk("t3_wstrb",   32'(wstrb),   32'h3);
        wready = 1'b1; tick(); wready = 1'b0; #1;
        chk("t3_wdrop",  32'(wvalid),  32'd0);
        chk("t3_awhold", 32'(awvalid), 32'd1);
        tick(); #1;
        chk("t3_awhold2", 32'(awvalid), 32'd1);
        chk("t3_dok_send", 32'(data_sram_data_ok), 32'd0);
        awready = 1'b1; tick(); awready = 1'b0; #1;
        chk("t3_awdrop", 32'(awvalid), 32'd0);
        chk("t3_dok_resp_wait", 32'(data_sram_data_ok), 32'd0);
        bvalid = 1'b1; #1;
        chk("t3_dok_b", 32'(data_sram_data_ok), 32'd1);
        tick(); #1;
        chk("t3_stray_b", 32'(data_sram_data_ok), 32'd0);
        bvalid = 1'b0;

        // read-after-write hazard on the fetch side
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
        data_sram_wstrb = 4'hF; data_sram_addr = 32'h1C002004;
        data_sram_wdata = 32'h00005678; #1;
        chk("t4_daok", 32'(data_sram_addr_ok), 32'd1);
        tick(); data_sram_req = 1'b0; data_sram_wr = 1'b0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C002004; #1;
        chk("t4_hazard", 32'(inst_sram_addr_ok), 32'd0);
        inst_sram_addr = 32'h1C002008; #1;
        chk("t4_nohazard", 32'(inst_sram_addr_ok), 32'd1);
        arready = 1'b1; tick(); inst_sram_req = 1'b0; #1;
        chk("t4_araddr", araddr, 32'h1C002008);
        tick(); arready = 1'b0;
        rbeat(4'd0, 32'hCAFEF00D);
        chk("t4_idok", 32'(inst_sram_data_ok), 32'd1);
        tick(); rvalid = 1'b0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C002004; #1;
        chk("t4_hazard_send", 32'(inst_sram_addr_ok), 32'd0);
        awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0; #1;
        chk("t4_hazard_resp", 32'(inst_sram_addr_ok), 32'd0);
        bvalid = 1'b1; #1;
        chk("t4_dok_b",      32'(data_sram_data_ok), 32'd1);
        chk("t4_hazard_b",   32'(inst_sram_addr_ok), 32'd0);
        tick(); bvalid = 1'b0; #1;
        chk("t4_hazard_clr", 32'(inst_sram_addr_ok), 32'd1);
        inst_sram_req = 1'b0;

        // reset while AR is pending, then stray beats
        tick();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000020; #1;
        chk("t5_iaok", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; #1;
        chk("t5_arvalid", 32'(arvalid), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("t5_arvalid_rst", 32'(arvalid), 32'd0);
        rbeat(4'd0, 32'hDEADBEEF);
        chk("t5_stray_i", 32'(inst_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0;
        rbeat(4'd1, 32'hDEADBEEF);
        chk("t5_stray_d", 32'(data_sram_data_ok), 32'd0);
        tick(); rvalid = 1'b0;

        // back-to-back fetch accepted on its predecessor's data_ok
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000040; arready = 1'b1; #1;
        chk("t6_iaok", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0;
        tick();
        rbeat(4'd0, 32'h0BADCAFE);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000044; #1;
        chk("t6_idok",  32'(inst_sram_data_ok), 32'd1);
        chk("t6_iaok2", 32'(inst_sram_addr_ok), 32'd1);
        tick(); inst_sram_req = 1'b0; rvalid = 1'b0; #1;
        chk("t6_araddr", araddr, 32'h1C000044);
        chk("t6_arvalid", 32'(arvalid), 32'd1);
        tick(); arready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Sits directly downstream of the CPU core and converts its two SRAM-like ports (inst read-only, data read/write) into a single AXI3 master; the top level ties off the constant AXI fields (len=0, burst=1, lock/cache/prot=0, awid/wid=1, wlast=1, rready=1, bready=1).

Parameters:
DATA_RID, 4'd1, AXI ID used for data reads; instruction reads always use ID 4'd0.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_sram_req  in  1  inst read request
inst_sram_addr  in  32  inst read address, word access
inst_sram_addr_ok  out  1  inst request accepted this cycle
inst_sram_data_ok  out  1  inst read data valid
inst_sram_rdata  out  32  inst read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  0=byte, 1=half, 2=word
data_sram_wstrb  in  4  write byte strobes
data_sram_addr  in  32  data address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  data request accepted this cycle
data_sram_data_ok  out  1  read data valid or write complete
data_sram_rdata  out  32  data read data
arid  out  4  0 inst, DATA_RID data
araddr  out  32  read address
arsize  out  3  {1'b0,size}; inst always 3'd2
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  read response ID
rdata  in  32  read data
rvalid  in  1  read data valid
awaddr  out  32  write address
awsize  out  3  {1'b0,data_sram_size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  write response valid

Behaviour:
- Reset: arvalid/awvalid/wvalid=0, all outstanding flags clear, read FSM R_IDLE, write FSM W_IDLE; addr_ok/data_ok low. Reset mid-transaction drops all state; later R/B beats with no matching flag are ignored (no data_ok).
- Ownership: inst side and data side each have at most one outstanding transaction (flags inst_busy, data_busy). addr_ok is combinational: req & ~side_busy & channel free & no hazard; on addr_ok the request is latched into AR or AW/W registers and side_busy set.
- Read FSM: R_IDLE -> R_AR on accepting a read; arvalid=1 from the next cycle, AR fields held stable until arready; R_AR -> R_IDLE on arvalid&arready. Reads are accepted only in R_IDLE. Same-cycle inst and data read: data wins; inst_addr_ok=0 that cycle.
- Write FSM: W_IDLE -> W_SEND on accepting a write; awvalid and wvalid raised next cycle, each dropped independently on its own handshake; W_SEND -> W_RESP when both done; W_RESP -> W_IDLE on bvalid.
- RAW hazard: while write FSM not W_IDLE, an inst read with addr[31:2]==awaddr[31:2] is not accepted.
- Responses: inst_sram_data_ok = rvalid & rid==0 & inst_busy; data_sram_data_ok = (rvalid & rid==DATA_RID & data_busy) | (bvalid & W_RESP); rdata passes through to both sides; flag cleared on the same beat. Back-to-back: a new request may be accepted in the cycle its own data_ok fires (flag cleared combinationally for addr_ok).

Optional Feature:
AXI_BRIDGE_RBUF_EN: when defined, rid/rdata/rvalid are registered before decode, so read data_ok and rdata arrive 1 cycle after the R beat (write path unchanged). When undefined, read data_ok is combinational from rvalid, with 0 extra cycles.

Test Plan:
- inst req addr 0x1C000000 with arready=1, R beat rid=0 rdata=0x02800C0C 3 cycles later -> addr_ok cycle 0, arvalid cycle 1 with arid=0 and arsize=2, inst data_ok=1 with rdata 0x02800C0C on the R beat.
- inst and data reads in the same cycle (data addr 0x1C001000 size=0) -> data addr_ok only, arid=1 and arsize=0 first; inst accepted the cycle AR completes.
- data write addr 0x1C002004 wstrb=4'b0011 wdata=0x1234, with awready delayed 2 cycles relative to wready -> wvalid drops after its handshake, awvalid is held until its own; data_ok only on bvalid.
- pending write to 0x1C002004 plus an inst read of 0x1C002004 -> inst addr_ok stays low until bvalid; an inst read of 0x1C002008 is accepted immediately.
- reset asserted in R_AR with arvalid=1 -> next cycle arvalid=0; a later stray rvalid rid=0 produces no data_ok.
